// File: rtl/driver_monitor_readout.sv
// Reader side of the address-FIFO gap monitor: snapshots the gap histogram and
// cycle counter on a trigger and streams them as an 11-word framed packet.
module driver_monitor_readout #(
  parameter logic [7:0] MAGIC    = 8'hA5,
  parameter int         NUM_BINS = 16,
  parameter int         BIN_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      end_program,
  input  logic                      snap_req,
  input  logic                      abort,
  input  logic [31:0]               addr_cycle_cnt,
  input  logic [NUM_BINS*BIN_W-1:0] addr_mon_cnts_flat,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [31:0]               rd_data,
  output logic                      rd_last,
  output logic                      busy,
  output logic [7:0]                drop_cnt,
  input  logic [3:0]                mon_sel,
  output logic [BIN_W-1:0]          mon_sel_data
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic             end_program_d;
  logic [BIN_W-1:0] snap_bins [NUM_BINS];
  logic [31:0]      snap_cyc;
  logic [7:0]       seq;
  logic [3:0]       idx;
  logic [31:0]      csum;

  logic             trig;
  logic [3:0]       nxt_idx;
  logic [2:0]       pair;
  logic [31:0]      nxt_csum;
  logic [31:0]      nxt_word;

  assign trig = snap_req | (end_program & ~end_program_d);

  // Next word of the frame, built only from the frozen snapshot; word10 folds
  // the word currently on the bus into the running XOR.
  always_comb begin
    nxt_idx  = idx + 4'd1;
    pair     = 3'(nxt_idx - 4'd1);
    nxt_csum = csum ^ rd_data;
    nxt_word = '0;
    if (nxt_idx >= 4'd1 && nxt_idx <= 4'd8)
      nxt_word = {snap_bins[{pair, 1'b1}], snap_bins[{pair, 1'b0}]};
    else if (nxt_idx == 4'd9)
      nxt_word = snap_cyc;
    else if (nxt_idx == 4'd10)
      nxt_word = nxt_csum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      end_program_d <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) snap_bins[i] <= '0;
      snap_cyc      <= '0;
      seq           <= '0;
      idx           <= '0;
      csum          <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_last       <= 1'b0;
      busy          <= 1'b0;
      drop_cnt      <= '0;
      mon_sel_data  <= '0;
    end else begin
      end_program_d <= end_program;
      mon_sel_data  <= snap_bins[mon_sel];

      if (trig && state == SEND && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (trig) begin
            for (int i = 0; i < NUM_BINS; i++)
              snap_bins[i] <= addr_mon_cnts_flat[BIN_W*i +: BIN_W];
            snap_cyc <= addr_cycle_cnt;
            idx      <= '0;
            csum     <= '0;
            rd_data  <= {MAGIC, seq, 16'(NUM_BINS)};
            rd_last  <= 1'b0;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // Abort beats a coinciding handshake: the word is discarded.
          if (abort) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (rd_valid && rd_ready) begin
            if (rd_last) begin
              seq      <= seq + 8'd1;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= nxt_idx;
              csum    <= nxt_csum;
              rd_data <= nxt_word;
              rd_last <= (nxt_idx == 4'd10);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_driver_monitor_readout.sv
// Scoreboard bench for driver_monitor_readout: expected frames are queued when a
// trigger is driven and popped as words transfer on the stream.
module tb_driver_monitor_readout;

  logic         clk;
  logic         reset;
  logic         end_program;
  logic         snap_req;
  logic         abort;
  logic [31:0]  addr_cycle_cnt;
  logic [255:0] addr_mon_cnts_flat;
  logic         rd_valid;
  logic         rd_ready;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         busy;
  logic [7:0]   drop_cnt;
  logic [3:0]   mon_sel;
  logic [15:0]  mon_sel_data;

  driver_monitor_readout dut (
    .clk                (clk),
    .reset              (reset),
    .end_program        (end_program),
    .snap_req           (snap_req),
    .abort              (abort),
    .addr_cycle_cnt     (addr_cycle_cnt),
    .addr_mon_cnts_flat (addr_mon_cnts_flat),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_data            (rd_data),
    .rd_last            (rd_last),
    .busy               (busy),
    .drop_cnt           (drop_cnt),
    .mon_sel            (mon_sel),
    .mon_sel_data       (mon_sel_data)
  );

  int          checkCount = 0;
  int          passCount  = 0;
  logic [32:0] sb [$];
  logic [31:0] seen [$];
  int          readyMode = 0;
  logic [7:0]  expSeq = 8'd0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    else
      passCount++;
  endtask

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready
  initial begin
    int cyc = 0;
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: rd_ready = 1'b1;
        1: rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rd_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // Monitor: a word with valid&ready at the negedge transfers on the next posedge
  always @(negedge clk) begin
    if (!reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", 32'(rd_valid), 32'd1);
        checkOutput("stallData", rd_data, prevData);
        checkOutput("stallLast", 32'(rd_last), 32'(prevLast));
      end
      if (rd_valid && rd_ready && !abort) begin
        seen.push_back(rd_data);
        if (sb.size() == 0) begin
          checkOutput("unexpectedWord", 32'(sb.size() == 0), 32'd0);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          checkOutput("word", rd_data, e[31:0]);
          checkOutput("last", 32'(rd_last), 32'(e[32]));
        end
      end
      prevStall = rd_valid && !rd_ready;
      prevData  = rd_data;
      prevLast  = rd_last;
    end
  end

  task automatic setBins();
    for (int i = 0; i < 16; i++) addr_mon_cnts_flat[16*i +: 16] = 16'(16'h0100 + i);
    addr_cycle_cnt = 32'h0000_1234;
  endtask

  task automatic pushFrame(input logic [7:0] seqVal);
    logic [31:0] w;
    logic [31:0] x;
    w = {8'hA5, seqVal, 16'd16};
    x = w;
    sb.push_back({1'b0, w});
    for (int k = 1; k <= 8; k++) begin
      w = addr_mon_cnts_flat[32*(k-1) +: 32];
      x = x ^ w;
      sb.push_back({1'b0, w});
    end
    x = x ^ addr_cycle_cnt;
    sb.push_back({1'b0, addr_cycle_cnt});
    sb.push_back({1'b1, x});
  endtask

  task automatic applyStimulus();
    seen.delete();
    pushFrame(expSeq);
    @(posedge clk);
    #1 snap_req = 1'b1;
    @(posedge clk);
    #1 snap_req = 1'b0;
    checkOutput("validLatency", 32'(rd_valid), 32'd1);
    checkOutput("busyHigh", 32'(busy), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || rd_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("frameDone", 32'(sb.size()), 32'd0);
    checkOutput("idleValid", 32'(rd_valid), 32'd0);
  endtask

  task automatic waitWords(input int count);
    int n = 0;
    while (seen.size() < count && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("wordsReached", 32'(seen.size()), 32'(count));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_data"}, rd_data, 32'd0);
    checkOutput({tag, "_last"}, 32'(rd_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    checkOutput({tag, "_monsel"}, 32'(mon_sel_data), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    end_program = 1'b0;
    snap_req = 1'b0;
    abort = 1'b0;
    mon_sel = 4'd0;
    setBins();
    #1;
    checkAllZero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Basic frame and its literal contents, then a second frame's seq
    applyStimulus();
    waitIdle(40);
    expSeq++;
    checkOutput("f1Size", 32'(seen.size()), 32'd11);
    if (seen.size() == 11) begin
      checkOutput("f1Word0", seen[0], 32'hA500_0010);
      checkOutput("f1Word1", seen[1], 32'h0101_0100);
      checkOutput("f1Word8", seen[8], 32'h010F_010E);
      checkOutput("f1Word9", seen[9], 32'h0000_1234);
    end
    applyStimulus();
    waitIdle(40);
    expSeq++;
    if (seen.size() > 0) checkOutput("f2Word0", seen[0], 32'hA501_0010);

    // Backpressure pattern
    readyMode = 1;
    applyStimulus();
    waitIdle(200);
    expSeq++;
    checkOutput("stallSize", 32'(seen.size()), 32'd11);
    readyMode = 0;

    // end_program held high: one frame, busy trigger dropped
    seen.delete();
    pushFrame(expSeq);
    @(posedge clk);
    #1 end_program = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1 snap_req = 1'b1;
    @(posedge clk);
    #1 snap_req = 1'b0;
    checkOutput("dropOne", 32'(drop_cnt), 32'd1);
    repeat (15) @(posedge clk);
    #1 end_program = 1'b0;
    waitIdle(40);
    expSeq++;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("oneFrame", 32'(seen.size()), 32'd11);

    // Drop counter saturation while a frame stalls
    readyMode = 2;
    applyStimulus();
    snap_req = 1'b1;
    repeat (300) @(posedge clk);
    #1 snap_req = 1'b0;
    checkOutput("dropSat", 32'(drop_cnt), 32'h0000_00FF);
    readyMode = 0;
    waitIdle(40);
    expSeq++;

    // Live inputs change right after the trigger
    applyStimulus();
    addr_mon_cnts_flat = '1;
    addr_cycle_cnt = 32'hDEAD_BEEF;
    waitIdle(40);
    expSeq++;
    setBins();

    // Abort coinciding with the word5 handshake
    applyStimulus();
    waitWords(5);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abortValid", 32'(rd_valid), 32'd0);
    checkOutput("abortLast", 32'(rd_last), 32'd0);
    checkOutput("abortSeen", 32'(seen.size()), 32'd5);
    sb.delete();

    // Abort on the word10 handshake: frame discarded, seq unchanged
    applyStimulus();
    waitWords(10);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort10Valid", 32'(rd_valid), 32'd0);
    sb.delete();
    applyStimulus();
    waitIdle(40);
    if (seen.size() > 0) checkOutput("seqKept", seen[0], {8'hA5, expSeq, 16'd16});
    expSeq++;

    // Reset mid-frame under backpressure
    readyMode = 2;
    applyStimulus();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkAllZero("midReset");
    sb.delete();
    seen.delete();
    expSeq = 8'd0;
    readyMode = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    mon_sel = 4'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("monSelCleared", 32'(mon_sel_data), 32'd0);
    applyStimulus();
    @(posedge clk);
    #1;
    checkOutput("monSelBin3", 32'(mon_sel_data), 32'h0000_0103);
    waitIdle(40);
    if (seen.size() > 0) checkOutput("postResetSeq", seen[0], 32'hA500_0010);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/driver_monitor_readout.md
Name: driver_monitor_readout

Overview:
Reader side of the driver address-FIFO gap monitor. It captures the 16-bin gap histogram and the running cycle counter into a snapshot on a trigger. It then streams the snapshot as an 11-word framed packet over a valid/ready interface to the host capture path. It also provides a registered single-bin read port for debug register access.

Parameters:
MAGIC, 8'hA5, header tag placed in word0[31:24]
NUM_BINS, 16, histogram bin count; fixed, not for override
BIN_W, 16, width of each histogram bin

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
end_program  input  1  level; its rising edge triggers a snapshot
snap_req  input  1  single-cycle software snapshot request
abort  input  1  single-cycle request to drop the frame in flight
addr_cycle_cnt  input  32  live gap counter from the monitor
addr_mon_cnts_flat  input  256  live bins; bin i is at bits [16i+15:16i]
rd_valid  output  1  stream word valid
rd_ready  input  1  downstream accept
rd_data  output  32  stream word
rd_last  output  1  marks the final word (word10)
busy  output  1  high while a frame is in flight
drop_cnt  output  8  triggers dropped because a frame was busy; saturates at 8'hFF
mon_sel  input  4  bin index for the debug read port
mon_sel_data  output  16  snapshot bin[mon_sel], registered

Behaviour:
- Reset is asynchronous and active-low. On assertion all outputs go to 0 immediately: rd_valid, rd_data, rd_last, busy, drop_cnt and mon_sel_data. The snapshot registers, seq and the end_program edge register are also cleared. A reset mid-frame drops the frame silently, with no rd_last.
- Trigger: trig = snap_req OR (end_program AND NOT end_program_d), where end_program_d is end_program registered.
- FSM states:
  - IDLE -> SEND when trig is sampled.
  - SEND -> IDLE on handshake of word10.
  - SEND -> IDLE on abort.
- On the trigger edge in IDLE:
  - load snap_bins from addr_mon_cnts_flat and snap_cyc from addr_cycle_cnt;
  - clear word index idx and the checksum accumulator;
  - assert rd_valid starting the next cycle, so word0 is presented one cycle after the trigger.
- Frame words, each formed from the snapshot only:
  - word0 = {MAGIC, seq[7:0], 16'd16}
  - word k = {bin[2k-1], bin[2k-2]} for k = 1..8
  - word9 = snap_cyc
  - word10 = XOR of words 0..9; rd_last = 1 on word10 only
- Handshake: a word transfers on a clock edge with rd_valid AND rd_ready. rd_data and rd_last hold stable while rd_valid is high and rd_ready is low. rd_valid never drops without a transfer, except on abort or reset. Back-to-back transfers run at one word per cycle.
- After word10 transfers: seq increments and wraps from 255 to 0; rd_valid deasserts the next cycle; the FSM returns to IDLE. A trigger in that return cycle is accepted normally, so the new word0 appears one cycle later.
- busy = 1 in SEND.
- A trig while busy is dropped and drop_cnt increments, saturating at 255. The snapshot is not modified.
- Abort in SEND: return to IDLE and clear rd_valid and rd_last the next cycle. seq does not increment. If abort and handshake fall on the same edge, abort wins and the word counts as discarded.
- A simultaneous snap_req and end_program rising edge is one trigger.
- mon_sel_data <= snap_bins[mon_sel] every cycle, giving 1-cycle latency. It reads 0 until the first snapshot after reset.
- The live inputs may change freely during SEND; the frame content is unaffected.

Test Plan:
- Bins i = 16'h0100+i, addr_cycle_cnt = 32'h0000_1234, snap_req pulse with rd_ready = 1:
  - 11 consecutive words starting the cycle after the pulse: word0 = 32'hA500_0010, word1 = 32'h0101_0100, word8 = 32'h010F_010E, word9 = 32'h0000_1234;
  - word10 = XOR of words 0..9, with rd_last high only on word10;
  - a second frame has word0 = 32'hA501_0010.
- Same setup, rd_ready toggled 1,0,0,1 repeatedly:
  - rd_data is stable across every stall;
  - no words are lost or duplicated and the word order is unchanged.
- Hold end_program high for 20 cycles:
  - exactly one frame is sent;
  - a snap_req at word 3 makes drop_cnt = 1 and the frame continues unchanged;
  - 300 further busy triggers leave drop_cnt = 8'hFF.
- Change the live bins to 16'hFFFF right after the trigger: the frame still carries the original snapshot values.
- Abort at word 5: rd_valid is low the next cycle; the next frame's seq is unchanged. Abort on the same edge as a word handshake: the abort takes precedence.
- Assert reset while rd_valid is high with rd_ready low:
  - all outputs are 0 with no clock edge needed;
  - after release, mon_sel = 4'd3 gives mon_sel_data = 0, and after a new snapshot gives bin3 one cycle later.
